// File: rtl/bdd_reduce_normalize_pkg.sv
// Shared widths, order-buffer entry layout and index helpers for the
// BDD reduce/normalise stage.
package bdd_reduce_normalize_pkg;

  localparam int INDEX_W = 30;
  localparam int VAR_W   = 10;

  localparam logic [INDEX_W-1:0] BDD_ZERO = 30'd0;
  localparam logic [31:0]        STAT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic               done;
    logic               neg;
    logic [INDEX_W-1:0] value;
  } reduce_entry_t;

  function automatic logic index_negate(input logic [INDEX_W-1:0] x);
    return x[0];
  endfunction

  function automatic logic [INDEX_W-1:0] index_flip(input logic [INDEX_W-1:0] x);
    return x ^ {{(INDEX_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x, input logic en);
    return (en && (x != STAT_MAX)) ? (x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/bdd_reduce_normalize_order_buffer.sv
// Circular in-order result buffer: bypass entries arrive done, normal entries
// are completed by find-or-insert returns through the fill pointer.
module reduce_order_buffer
  import bdd_reduce_normalize_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               push_done,
  input  logic               push_neg,
  input  logic [INDEX_W-1:0] push_value,
  input  logic               pop,
  input  logic               foi_validOut,
  input  logic [INDEX_W-1:0] foi_result,
  output logic               full,
  output logic               head_done,
  output logic [INDEX_W-1:0] head_value
);

  localparam logic [PTR_BITS:0] COUNT_FULL = (PTR_BITS+1)'(DEPTH);
  localparam logic [PTR_BITS:0] COUNT_ONE  = (PTR_BITS+1)'(1);

  reduce_entry_t         mem [DEPTH];
  logic [PTR_BITS-1:0]   head;
  logic [PTR_BITS-1:0]   tail;
  logic [PTR_BITS-1:0]   fill;
  logic [PTR_BITS:0]     count;
  logic                  err;

  logic [PTR_BITS-1:0]   fill_dist;
  logic                  fill_ok;
  logic                  foi_write;
  logic [PTR_BITS-1:0]   fill_next;
  logic                  found;

  // Fill pointer tracking: next oldest not-done entry, skipping the one completed this cycle.
  always_comb begin
    fill_dist = fill - head;
    fill_ok   = ({1'b0, fill_dist} < count) && !mem[fill].done;
    foi_write = foi_validOut && fill_ok;
    fill_next = tail;
    found     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_BITS-1:0] p;
      logic [PTR_BITS-1:0] d;
      logic                hit;
      p         = fill + PTR_BITS'(i);
      d         = p - head;
      hit       = ({1'b0, d} < count) && !mem[p].done && !(foi_write && (p == fill));
      fill_next = (!found && hit) ? p : fill_next;
      found     = found | hit;
    end
    full       = (count == COUNT_FULL);
    head_done  = (count != {(PTR_BITS+1){1'b0}}) && mem[head].done;
    head_value = mem[head].value;
  end

  // Storage, pointers and count; a return with nothing pending only raises the sticky error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= {PTR_BITS{1'b0}};
      tail  <= {PTR_BITS{1'b0}};
      fill  <= {PTR_BITS{1'b0}};
      count <= {(PTR_BITS+1){1'b0}};
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (foi_write) begin
        mem[fill].done  <= 1'b1;
        mem[fill].value <= foi_result ^ {{(INDEX_W-1){1'b0}}, mem[fill].neg};
      end
      if (push) begin
        mem[tail] <= '{done: push_done, neg: push_neg, value: push_value};
        tail      <= tail + PTR_BITS'(1);
      end
      if (pop) begin
        head <= head + PTR_BITS'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
      fill <= fill_next;
      err  <= err | (foi_validOut && !fill_ok);
    end
  end

endmodule

// File: rtl/bdd_reduce_normalize.sv
// BDD reduce/normalise stage in front of find-or-insert, results returned in order.
// Optional counters: define REDUCE_STATS_EN for stat_bypass/stat_negate/stat_issue.
module bdd_reduce_normalize
  import bdd_reduce_normalize_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PTR_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] e,
  input  logic [INDEX_W-1:0] t,
  input  logic [VAR_W-1:0]   top,
  input  logic               valid,
  output logic               busy,
  output logic [INDEX_W-1:0] result,
  output logic               validOut,
  input  logic               busyIn,
  output logic [INDEX_W-1:0] foi_e,
  output logic [INDEX_W-1:0] foi_t,
  output logic [VAR_W-1:0]   foi_top,
  output logic               foi_valid,
  input  logic               foi_busy,
  input  logic [INDEX_W-1:0] foi_result,
  input  logic               foi_validOut
`ifdef REDUCE_STATS_EN
  ,
  output logic [31:0]        stat_bypass,
  output logic [31:0]        stat_negate,
  output logic [31:0]        stat_issue
`endif
);

  logic               bypass;
  logic               norm_neg;
  logic [INDEX_W-1:0] norm_e;
  logic [INDEX_W-1:0] norm_t;
  logic               accept;
  logic               dispatch;
  logic               pop;
  logic               full;
  logic               head_done;
  logic [INDEX_W-1:0] head_value;
  logic               issue_hold;
  logic [INDEX_W-1:0] push_value;

  // Classification; equal edges never reach find-or-insert and are not normalised.
  always_comb begin
    bypass     = (e == t);
    norm_neg   = index_negate(t);
    norm_e     = norm_neg ? index_flip(e) : e;
    norm_t     = norm_neg ? index_flip(t) : t;
    busy       = full || (!bypass && (foi_busy || issue_hold));
    accept     = valid && !busy;
    dispatch   = accept && !bypass;
    pop        = head_done && !busyIn;
    push_value = bypass ? e : BDD_ZERO;
  end

  reduce_order_buffer #(
    .DEPTH    (DEPTH),
    .PTR_BITS (PTR_BITS)
  ) u_order (
    .clk          (clk),
    .reset        (reset),
    .push         (accept),
    .push_done    (bypass),
    .push_neg     (norm_neg && !bypass),
    .push_value   (push_value),
    .pop          (pop),
    .foi_validOut (foi_validOut),
    .foi_result   (foi_result),
    .full         (full),
    .head_done    (head_done),
    .head_value   (head_value)
  );

  // Dispatch register; issue_hold masks the cycle before find-or-insert can raise foi_busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      foi_e      <= BDD_ZERO;
      foi_t      <= BDD_ZERO;
      foi_top    <= {VAR_W{1'b0}};
      foi_valid  <= 1'b0;
      issue_hold <= 1'b0;
    end else begin
      foi_valid  <= dispatch;
      issue_hold <= dispatch;
      if (dispatch) begin
        foi_e   <= norm_e;
        foi_t   <= norm_t;
        foi_top <= top;
      end
    end
  end

  // Output register; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      result   <= BDD_ZERO;
      validOut <= 1'b0;
    end else if (!busyIn) begin
      validOut <= head_done;
      if (head_done) begin
        result <= head_value;
      end
    end
  end

`ifdef REDUCE_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_bypass <= 32'd0;
      stat_negate <= 32'd0;
      stat_issue  <= 32'd0;
    end else begin
      stat_bypass <= sat_inc(stat_bypass, accept && bypass);
      stat_negate <= sat_inc(stat_negate, dispatch && norm_neg);
      stat_issue  <= sat_inc(stat_issue, foi_valid);
    end
  end
`endif

endmodule

// File: tb/tb_bdd_reduce_normalize.sv
// Directed bench for bdd_reduce_normalize; find-or-insert responses are driven by hand.
module tb_bdd_reduce_normalize;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] e, t;
  logic [9:0]  top;
  logic        valid;
  logic        busy;
  logic [29:0] result;
  logic        validOut;
  logic        busyIn;
  logic [29:0] foi_e, foi_t;
  logic [9:0]  foi_top;
  logic        foi_valid;
  logic        foi_busy;
  logic [29:0] foi_result;
  logic        foi_validOut;
`ifdef REDUCE_STATS_EN
  logic [31:0] stat_bypass, stat_negate, stat_issue;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bdd_reduce_normalize dut (
    .clk          (clk),
    .reset        (reset),
    .e            (e),
    .t            (t),
    .top          (top),
    .valid        (valid),
    .busy         (busy),
    .result       (result),
    .validOut     (validOut),
    .busyIn       (busyIn),
    .foi_e        (foi_e),
    .foi_t        (foi_t),
    .foi_top      (foi_top),
    .foi_valid    (foi_valid),
    .foi_busy     (foi_busy),
    .foi_result   (foi_result),
    .foi_validOut (foi_validOut)
`ifdef REDUCE_STATS_EN
    ,
    .stat_bypass  (stat_bypass),
    .stat_negate  (stat_negate),
    .stat_issue   (stat_issue)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0; e = 30'd0; t = 30'd0; top = 10'd0; valid = 1'b0;
    busyIn = 1'b0; foi_busy = 1'b0; foi_result = 30'd0; foi_validOut = 1'b0;
    tick(); tick();
    chk("rst_validOut", {31'd0, validOut}, 32'd0);
    chk("rst_result", {2'd0, result}, 32'd0);
    chk("rst_foi_valid", {31'd0, foi_valid}, 32'd0);
    chk("rst_foi_e", {2'd0, foi_e}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick();

    // 1: bypass e==t
    e = 30'h10; t = 30'h10; valid = 1'b1;
    #1 chk("t1_busy", {31'd0, busy}, 32'd0);
    tick();
    valid = 1'b0;
    chk("t1_vo_n1", {31'd0, validOut}, 32'd0);
    chk("t1_foi_valid", {31'd0, foi_valid}, 32'd0);
    tick();
    chk("t1_vo_n2", {31'd0, validOut}, 32'd1);
    chk("t1_result", {2'd0, result}, 32'h10);
    chk("t1_foi_valid2", {31'd0, foi_valid}, 32'd0);
    tick();
    chk("t1_vo_done", {31'd0, validOut}, 32'd0);

    // e==t with negate flag set: returned unchanged, no dispatch
    e = 30'h7; t = 30'h7; valid = 1'b1;
    tick();
    valid = 1'b0;
    chk("tn_foi_valid", {31'd0, foi_valid}, 32'd0);
    tick();
    chk("tn_vo", {31'd0, validOut}, 32'd1);
    chk("tn_result", {2'd0, result}, 32'h7);
    tick();

    // 2: normal with negated then-edge
    e = 30'h20; t = 30'h41; top = 10'd3; valid = 1'b1;
    #1 chk("t2_busy", {31'd0, busy}, 32'd0);
    tick();
    valid = 1'b0;
    chk("t2_foi_valid", {31'd0, foi_valid}, 32'd1);
    chk("t2_foi_t", {2'd0, foi_t}, 32'h40);
    chk("t2_foi_e", {2'd0, foi_e}, 32'h21);
    chk("t2_foi_top", {22'd0, foi_top}, 32'd3);
    tick();
    chk("t2_foi_valid_1cyc", {31'd0, foi_valid}, 32'd0);
    foi_validOut = 1'b1; foi_result = 30'h80;
    tick();
    foi_validOut = 1'b0;
    chk("t2_vo_early", {31'd0, validOut}, 32'd0);
    tick();
    chk("t2_vo", {31'd0, validOut}, 32'd1);
    chk("t2_result", {2'd0, result}, 32'h81);
    tick();

    // 3: bypass B queued behind pending normal A
    e = 30'h100; t = 30'h200; top = 10'd5; valid = 1'b1;
    tick();
    chk("t3_foi_e", {2'd0, foi_e}, 32'h100);
    chk("t3_foi_t", {2'd0, foi_t}, 32'h200);
    e = 30'h6; t = 30'h6;
    #1 chk("t3_busy_b", {31'd0, busy}, 32'd0);
    tick();
    valid = 1'b0;
    tick();
    chk("t3_b_held", {31'd0, validOut}, 32'd0);
    foi_validOut = 1'b1; foi_result = 30'h300;
    tick();
    foi_validOut = 1'b0;
    chk("t3_b_held2", {31'd0, validOut}, 32'd0);
    tick();
    chk("t3_a_vo", {31'd0, validOut}, 32'd1);
    chk("t3_a_res", {2'd0, result}, 32'h300);
    tick();
    chk("t3_b_vo", {31'd0, validOut}, 32'd1);
    chk("t3_b_res", {2'd0, result}, 32'h6);
    tick();
    chk("t3_idle", {31'd0, validOut}, 32'd0);

    // 4: fill buffer under downstream stall, then drain in order
    busyIn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 30'h11 + 30'(i); t = 30'h11 + 30'(i); valid = 1'b1;
      #1 chk("t4_busy_fill", {31'd0, busy}, 32'd0);
      tick();
    end
    e = 30'h15; t = 30'h15; valid = 1'b1;
    #1 chk("t4_busy_full", {31'd0, busy}, 32'd1);
    valid = 1'b0;
    chk("t4_vo_stalled", {31'd0, validOut}, 32'd0);
    busyIn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_drain_vo", {31'd0, validOut}, 32'd1);
      chk("t4_drain_res", {2'd0, result}, 32'h11 + 32'(i));
    end
    tick();
    chk("t4_drained", {31'd0, validOut}, 32'd0);

    // 5: foi_busy blocks normal but not bypass
    foi_busy = 1'b1;
    e = 30'h2; t = 30'h4; valid = 1'b1;
    #1 chk("t5_busy_norm", {31'd0, busy}, 32'd1);
    tick();
    valid = 1'b0;
    chk("t5_no_dispatch", {31'd0, foi_valid}, 32'd0);
    e = 30'h8; t = 30'h8; valid = 1'b1;
    #1 chk("t5_busy_byp", {31'd0, busy}, 32'd0);
    tick();
    valid = 1'b0;
    tick();
    chk("t5_vo", {31'd0, validOut}, 32'd1);
    chk("t5_res", {2'd0, result}, 32'h8);
    foi_busy = 1'b0;
    tick();

    // 6: reset with entries pending
    busyIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = 30'h21 + 30'(i); t = 30'h21 + 30'(i); valid = 1'b1;
      tick();
    end
    valid = 1'b0; e = 30'd0; t = 30'd0;
    reset = 1'b0;
    tick();
    chk("t6_vo", {31'd0, validOut}, 32'd0);
    chk("t6_res", {2'd0, result}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1; busyIn = 1'b0;
    tick(); tick();
    chk("t6_empty", {31'd0, validOut}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
